scmp_alu_mdu: RTL

Parametrised multi-cycle arithmetic unit for the SC/MP datapath. It extends the single-cycle ALU with four operations: binary add, packed-BCD decimal add, unsigned multiply and unsigned divide. Operand width is generic, so the same block serves 8-bit and wider accumulator/extension register pairs. It sits beside the combinational ALU and is driven by the execute sequencer through a start/busy/done handshake.

---
 rtl/scmp_alu_mdu.sv | 134 +++++++++++++
 1 files changed

// File: rtl/scmp_alu_mdu.sv
// scmp_alu_mdu: multi-cycle ADD / packed-BCD DAD / unsigned MPY / unsigned DIV unit with start/busy/done handshake
module scmp_alu_mdu #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cy_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] res_o,
  output logic [W-1:0] ext_o,
  output logic         cy_o,
  output logic         ov_o
);
  localparam int CW = $clog2(W + 1);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_DAD = 3'd1;
  localparam logic [2:0] OP_MPY = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lat;
  logic [2:0] op_q, op_d, op_c;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_d, ext_d;
  logic [W-1:0] a_c, b_c, r_c, e_c, diff;
  logic cy_d, ov_d, done_d, accept, c_c, geq;
  logic [W:0] sum, madd, trial;
  logic [4:0] ds;
  logic [3:0] dig;
  assign busy_o = state_q == RUN;
  // Next state plus one datapath step; the accepting edge already performs the first step from the raw inputs
  always_comb begin
    accept = state_q == IDLE && start_i;
    op_c = accept ? op_i : op_q;
    a_c = accept ? a_i : a_q;
    b_c = accept ? b_i : b_q;
    r_c = accept ? (op_i == OP_MPY ? b_i : a_i) : res_o;
    e_c = accept ? '0 : ext_o;
    c_c = accept ? cy_i : cy_o;
    lat = op_i == OP_DAD ? CW'(W / 4) :
          op_i == OP_MPY ? CW'(W) :
          op_i == OP_DIV ? (b_i == '0 ? CW'(1) : CW'(W)) : CW'(1);
    sum = {1'b0, a_c} + {1'b0, b_c} + {{W{1'b0}}, c_c};
    ds = {1'b0, a_c[3:0]} + {1'b0, b_c[3:0]} + {4'b0, c_c};
    dig = ds[3:0] + (ds > 5'd9 ? 4'd6 : 4'd0);
    madd = r_c[0] ? {1'b0, e_c} + {1'b0, a_c} : {1'b0, e_c};
    trial = {e_c, r_c[W-1]};
    geq = trial >= {1'b0, b_c};
    diff = trial[W-1:0] - b_c;
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_o;
    ext_d = ext_o;
    cy_d = cy_o;
    ov_d = ov_o;
    done_d = 1'b0;
    if (accept || (state_q == RUN && cnt_q != '0)) begin
      state_d = RUN;
      cnt_d = accept ? lat - CW'(1) : cnt_q - CW'(1);
      done_d = accept ? lat == CW'(1) : cnt_q == CW'(1);
      op_d = op_c;
      a_d = a_c;
      b_d = b_c;
      case (op_c)
        OP_ADD: begin
          res_d = sum[W-1:0];
          ext_d = '0;
          cy_d = sum[W];
          ov_d = (a_c[W-1] == b_c[W-1]) && (sum[W-1] != a_c[W-1]);
        end
        OP_DAD: begin
          res_d = {dig, r_c[W-1:4]};
          ext_d = '0;
          cy_d = ds > 5'd9;
          ov_d = 1'b0;
          a_d = a_c >> 4;
          b_d = b_c >> 4;
        end
        OP_MPY: begin
          {ext_d, res_d} = {madd, r_c[W-1:1]};
          cy_d = 1'b0;
          ov_d = madd[W:1] != '0;
        end
        OP_DIV: begin
          res_d = b_c == '0 ? '1 : {r_c[W-2:0], geq};
          ext_d = b_c == '0 ? a_c : (geq ? diff : trial[W-1:0]);
          cy_d = 1'b0;
          ov_d = b_c == '0;
        end
        default: begin
          res_d = a_c;
          ext_d = '0;
          cy_d = c_c;
          ov_d = 1'b0;
        end
      endcase
    end else if (state_q == RUN) begin
      state_d = IDLE;
    end
  end
  // State, operand and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_o <= '0;
      ext_o <= '0;
      cy_o <= 1'b0;
      ov_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      res_o <= res_d;
      ext_o <= ext_d;
      cy_o <= cy_d;
      ov_o <= ov_d;
      done_o <= done_d;
    end
  end
endmodule
